// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle LEGv8 sequencer with run/idle, memory timeout trap and retire counter
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic             reg_to_loc,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             busy,
    output logic             error,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_NONE,
        C_RTYPE,
        C_LDUR,
        C_STUR,
        C_CBZ,
        C_B,
        C_ILLEGAL
    } class_t;

    // Last MEM wait cycle allowed before the trap fires.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    class_t      cls_q, dec_cls;
    logic [7:0]  wait_cnt;

    // Instruction class straight from the IR opcode field.
    always_comb begin
        dec_cls = C_ILLEGAL;
        if (opcode == 11'b10001011000 || opcode == 11'b11001011000 ||
            opcode == 11'b10001010000 || opcode == 11'b10101010000)
            dec_cls = C_RTYPE;
        else if (opcode == 11'b11111000010)
            dec_cls = C_LDUR;
        else if (opcode == 11'b11111000000)
            dec_cls = C_STUR;
        else if (opcode[10:3] == 8'b10110100)
            dec_cls = C_CBZ;
        else if (opcode[10:5] == 6'b000101)
            dec_cls = C_B;
    end

    // State, latched class, MEM wait counter and retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cls_q       <= C_NONE;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                cls_q <= dec_cls;
            if (state_d == S_MEM && state_q != S_MEM)
                wait_cnt <= '0;
            else if (state_q == S_MEM && !mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
            // Every instruction retires on its single pc_write cycle.
            if (pc_write)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Next state and Moore outputs; DECODE uses the live decode since the class is latched at its end.
    always_comb begin
        state_d    = state_q;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        reg_to_loc = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        error      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                if (dec_cls == C_B) begin
                    pc_write = 1'b1;
                    branch   = 1'b1;
                    state_d  = run ? S_FETCH : S_IDLE;
                end else if (dec_cls == C_ILLEGAL || dec_cls == C_NONE) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                reg_to_loc = (cls_q == C_STUR) || (cls_q == C_CBZ);
                case (cls_q)
                    C_RTYPE: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    C_LDUR, C_STUR: begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    C_CBZ: begin
                        alu_op   = 2'b01;
                        pc_write = 1'b1;
                        branch   = zero;
                        state_d  = run ? S_FETCH : S_IDLE;
                    end
                    default: state_d = S_ERROR;
                endcase
            end
            S_MEM: begin
                alu_src    = 1'b1;
                mem_read   = (cls_q == C_LDUR);
                mem_write  = (cls_q == C_STUR);
                reg_to_loc = (cls_q == C_STUR);
                if (cls_q != C_LDUR && cls_q != C_STUR) begin
                    state_d = S_ERROR;
                end else if (mem_ready) begin
                    if (cls_q == C_LDUR) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = run ? S_FETCH : S_IDLE;
                    end
                end else if (wait_cnt == TMO_LAST) begin
                    state_d = S_ERROR;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == C_LDUR);
                alu_op     = (cls_q == C_LDUR) ? 2'b00 : 2'b10;
                alu_src    = (cls_q == C_LDUR);
                pc_write   = 1'b1;
                state_d    = run ? S_FETCH : S_IDLE;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: state_d = S_ERROR;
        endcase
    end

    assign busy  = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset, run, zero, mem_ready;
    logic [10:0] opcode;
    logic        ir_write, pc_write, branch, reg_to_loc, alu_src;
    logic [1:0]  alu_op;
    logic        mem_read, mem_write, mem_to_reg, reg_write, busy, error;
    logic [2:0]  state;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010110101;
    localparam logic [10:0] OP_ILL  = 11'b00000000000;

    multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
        .branch(branch), .reg_to_loc(reg_to_loc), .alu_src(alu_src),
        .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .busy(busy),
        .error(error), .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock and land mid-low-phase, away from the rising edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_strobes"},
              32'({ir_write, pc_write, branch, reg_to_loc, alu_src, alu_op,
                   mem_read, mem_write, mem_to_reg, reg_write, busy}), 0);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = OP_ADD;
        #2;
        check("rst_state", 32'(state), 0);
        check_quiet("rst");
        check("rst_error", 32'(error), 0);
        check("rst_count", 32'(instr_count), 0);
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        check("idle_hold", 32'(state), 0);

        // ADD: FETCH, DECODE, EXEC, WB
        run = 1'b1; opcode = OP_ADD;
        cyc(); check("add_f", 32'(state), 1); check("add_irw", 32'(ir_write), 1); check("add_busy", 32'(busy), 1);
        cyc(); check("add_d", 32'(state), 2); check("add_d_pcw", 32'(pc_write), 0);
        cyc(); check("add_e", 32'(state), 3); check("add_aluop", 32'(alu_op), 2); check("add_alusrc", 32'(alu_src), 0);
        cyc(); check("add_wb", 32'(state), 5); check("add_rw", 32'(reg_write), 1);
        check("add_m2r", 32'(mem_to_reg), 0); check("add_pcw", 32'(pc_write), 1); check("add_br", 32'(branch), 0);
        check("add_cnt_before", 32'(instr_count), 0);
        cyc(); check("add_refetch", 32'(state), 1); check("add_cnt", 32'(instr_count), 1);

        // LDUR with three wait cycles
        opcode = OP_LDUR; mem_ready = 1'b0;
        cyc(); check("ld_d", 32'(state), 2);
        cyc(); check("ld_e", 32'(state), 3); check("ld_e_aluop", 32'(alu_op), 0); check("ld_e_src", 32'(alu_src), 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_ready = (i == 3);
            #1;
            check("ld_mem_state", 32'(state), 4);
            check("ld_mem_rd", 32'(mem_read), 1);
            check("ld_mem_wr", 32'(mem_write), 0);
            check("ld_mem_pcw", 32'(pc_write), 0);
        end
        cyc(); mem_ready = 1'b0; #1;
        check("ld_wb", 32'(state), 5); check("ld_m2r", 32'(mem_to_reg), 1); check("ld_rw", 32'(reg_write), 1);
        check("ld_wb_rd", 32'(mem_read), 0); check("ld_wb_pcw", 32'(pc_write), 1);
        cyc(); check("ld_cnt", 32'(instr_count), 2);

        // STUR with zero waits
        opcode = OP_STUR;
        cyc(); check("st_d", 32'(state), 2);
        cyc(); check("st_e", 32'(state), 3); check("st_e_r2l", 32'(reg_to_loc), 1);
        cyc(); mem_ready = 1'b1; #1;
        check("st_mem", 32'(state), 4); check("st_wr", 32'(mem_write), 1); check("st_pcw", 32'(pc_write), 1);
        check("st_br", 32'(branch), 0); check("st_rw", 32'(reg_write), 0); check("st_r2l", 32'(reg_to_loc), 1);
        cyc(); mem_ready = 1'b0; #1;
        check("st_refetch", 32'(state), 1); check("st_cnt", 32'(instr_count), 3);

        // CBZ taken then not taken
        opcode = OP_CBZ;
        cyc(); cyc(); zero = 1'b1; #1;
        check("cbz1_e", 32'(state), 3); check("cbz1_pcw", 32'(pc_write), 1); check("cbz1_br", 32'(branch), 1);
        check("cbz1_aluop", 32'(alu_op), 1); check("cbz1_r2l", 32'(reg_to_loc), 1);
        cyc(); check("cbz1_cnt", 32'(instr_count), 4);
        cyc(); cyc(); zero = 1'b0; #1;
        check("cbz0_pcw", 32'(pc_write), 1); check("cbz0_br", 32'(branch), 0);
        cyc(); check("cbz0_f", 32'(state), 1);

        // B retires in DECODE
        opcode = OP_B;
        cyc(); check("b_d", 32'(state), 2); check("b_pcw", 32'(pc_write), 1); check("b_br", 32'(branch), 1);
        cyc(); check("b_f", 32'(state), 1); check("b_cnt", 32'(instr_count), 6);

        // SUB with run dropped during EXEC
        opcode = OP_SUB;
        cyc(); cyc(); run = 1'b0; #1;
        check("sub_e", 32'(state), 3);
        cyc(); check("sub_wb", 32'(state), 5); check("sub_pcw", 32'(pc_write), 1);
        cyc(); check("sub_idle", 32'(state), 0); check("sub_busy", 32'(busy), 0); check("sub_cnt", 32'(instr_count), 7);
        cyc(); check("sub_idle2", 32'(state), 0);

        // Illegal opcode traps from DECODE
        run = 1'b1; opcode = OP_ILL;
        cyc(); cyc(); check("ill_d", 32'(state), 2);
        cyc(); check("ill_err", 32'(state), 6); check("ill_error", 32'(error), 1); check("ill_busy", 32'(busy), 0);
        run = 1'b0; cyc(); run = 1'b1; cyc();
        check("ill_sticky", 32'(state), 6); check("ill_cnt", 32'(instr_count), 7);

        // Clear the trap, then STUR that never sees mem_ready
        reset = 1'b1; #1;
        check("clr_state", 32'(state), 0); check("clr_error", 32'(error), 0);
        cyc(); reset = 1'b0; opcode = OP_STUR; mem_ready = 1'b0; run = 1'b1;
        cyc(); cyc(); cyc();
        for (int i = 0; i < 15; i++) begin
            cyc();
            check("tmo_mem", 32'(state), 4);
            check("tmo_wr", 32'(mem_write), 1);
            check("tmo_pcw", 32'(pc_write), 0);
        end
        cyc();
        check("tmo_err", 32'(state), 6); check("tmo_error", 32'(error), 1);
        check_quiet("tmo");
        check("tmo_cnt", 32'(instr_count), 0);
        mem_ready = 1'b1; run = 1'b0; cyc(); run = 1'b1; cyc();
        check("tmo_sticky", 32'(state), 6); check("tmo_cnt2", 32'(instr_count), 0);
        mem_ready = 1'b0;

        // Reset during the second MEM cycle of an LDUR
        reset = 1'b1; #1; cyc(); reset = 1'b0;
        opcode = OP_LDUR; run = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        check("rm_mem1", 32'(state), 4);
        cyc();
        check("rm_mem2", 32'(state), 4); check("rm_rd", 32'(mem_read), 1);
        reset = 1'b1; run = 1'b0; #1;
        check("rm_state", 32'(state), 0);
        check_quiet("rm");
        check("rm_error", 32'(error), 0);
        cyc(); reset = 1'b0;
        cyc(); cyc();
        check("rm_idle", 32'(state), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
